// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, slave FSM states and the transfer legality rule.
// Pure declarations; no timing or flow-control behaviour of its own.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RDW,
      ST_WR,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_ERR1,
      ST_ERR2
   } state_t;

   // Oversized or misaligned transfers are answered with ERROR.
   function automatic logic xfer_err(input logic [2:0] size, input logic [1:0] off);
      return (size > HSIZE_WORD) ||
             ((size == HSIZE_HALF) && off[0]) ||
             ((size == HSIZE_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-lite signals between the interconnect and the SRAM slave front end.
// Wires only; ready/valid semantics follow AHB-lite HREADY/HREADYOUT.
interface ahb_lite_sram_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_byte_merge.sv
// Combinational lane merge for sub-word writes: replaces size/offset lanes of old_word.
// Zero latency, no flow control.
module ahb_sram_byte_merge
   import ahb_lite_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   output logic [31:0] merged,
   output logic [3:0]  lane_mask
);

   always_comb begin
      lane_mask = 4'b0000;
      merged    = old_word;
      case (size)
         HSIZE_BYTE: lane_mask = 4'b0001 << offset;
         HSIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: lane_mask = 4'b1111;
         default:    lane_mask = 4'b0000;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (lane_mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave sequencing a 1-cycle-latency single-port SRAM; reads/word writes zero wait,
// read-after-write and sub-word writes (RMW) one wait, errors two-cycle; HREADYOUT stalls the bus.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int MEM_AW = 10,
   parameter int DW     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   ahb_lite_sram_slave_if.slave  bus,
   output logic [MEM_AW-1:0]     sram_addr,
   output logic [DW-1:0]         sram_data,
   output logic                  sram_wren,
   input  logic [DW-1:0]         sram_q
);

   state_t            state, state_nxt;
   logic              rdw_second, rdw_second_nxt;
   logic [MEM_AW-1:0] addr_q;
   logic [1:0]        off_q;
   logic [2:0]        size_q;
   logic              write_q;

   logic              accept, take, new_err;
   logic              hreadyout, hresp;
   logic [DW-1:0]     hrdata;
   logic [DW-1:0]     merged;
   logic [3:0]        lane_mask;
   logic              unused_bits;

   assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
   assign new_err     = xfer_err(bus.HSIZE, bus.HADDR[1:0]);
   assign unused_bits = ^{bus.HADDR[31:MEM_AW+2], bus.HTRANS[0]};

   assign bus.HREADYOUT = hreadyout;
   assign bus.HRESP     = hresp;
   assign bus.HRDATA    = hrdata;

   ahb_sram_byte_merge u_merge (
      .old_word  (sram_q),
      .new_word  (bus.HWDATA),
      .size      (size_q),
      .offset    (off_q),
      .merged    (merged),
      .lane_mask (lane_mask)
   );

   always_comb begin
      state_nxt      = state;
      rdw_second_nxt = 1'b0;
      hreadyout      = 1'b1;
      hresp          = HRESP_OKAY;
      hrdata         = '0;
      sram_addr      = bus.HADDR[MEM_AW+1:2];
      sram_data      = '0;
      sram_wren      = 1'b0;

      case (state)
         ST_RD: hrdata = sram_q;
         ST_RDW: begin
            // First cycle re-presents the read address the write cycle displaced.
            if (!rdw_second) begin
               sram_addr      = addr_q;
               hreadyout      = 1'b0;
               rdw_second_nxt = 1'b1;
            end else begin
               hrdata = sram_q;
            end
         end
         ST_WR: begin
            sram_addr = addr_q;
            sram_data = bus.HWDATA;
            sram_wren = write_q;
         end
         ST_RMW_RD: begin
            sram_addr = addr_q;
            hreadyout = 1'b0;
         end
         ST_RMW_WR: begin
            sram_addr = addr_q;
            sram_data = merged;
            sram_wren = write_q & (|lane_mask);
         end
         ST_ERR1: begin
            hresp     = HRESP_ERROR;
            hreadyout = 1'b0;
         end
         ST_ERR2: hresp = HRESP_ERROR;
         default: ;
      endcase

      take = accept & hreadyout;

      if (hreadyout) begin
         if (!accept)             state_nxt = ST_IDLE;
         else if (new_err)        state_nxt = ST_ERR1;
         else if (!bus.HWRITE)    state_nxt = sram_wren ? ST_RDW : ST_RD;
         else if (bus.HSIZE == HSIZE_WORD) state_nxt = ST_WR;
         else                     state_nxt = ST_RMW_RD;
      end else begin
         case (state)
            ST_RMW_RD: state_nxt = ST_RMW_WR;
            ST_ERR1:   state_nxt = ST_ERR2;
            default:   state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rdw_second <= 1'b0;
         addr_q     <= '0;
         off_q      <= '0;
         size_q     <= '0;
         write_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         rdw_second <= rdw_second_nxt;
         if (take) begin
            addr_q  <= bus.HADDR[MEM_AW+1:2];
            off_q   <= bus.HADDR[1:0];
            size_q  <= bus.HSIZE;
            write_q <= bus.HWRITE;
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Random and directed AHB-lite traffic against a transaction-level model of the SRAM slave.
module tb_ahb_lite_sram_slave;
   import ahb_lite_pkg::*;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [9:0]  sram_addr;
   logic [31:0] sram_data;
   logic [31:0] sram_q;
   logic        sram_wren;

   always #5 clk = ~clk;

   ahb_lite_sram_slave_if bus();
   assign bus.HREADY = bus.HREADYOUT;

   ahb_lite_sram_slave #(.MEM_AW(10), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .sram_wren (sram_wren),
      .sram_q    (sram_q)
   );

   // 1024x32 SRAM: registered read address, q one cycle later, word writes only.
   logic [31:0] mem [1024];
   logic [9:0]  ra;

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'h1111_1111;
      return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else if (sram_wren) begin
         mem[sram_addr] <= sram_data;
      end
      ra <= sram_addr;
   end
   assign sram_q = mem[ra];

   // Reference state
   logic [31:0] ref_mem [1024];
   xfer_t       q[$];
   xfer_t       ap;
   xfer_t       dp;
   bit          dp_vld;
   bit          dp_err;
   int          dp_exp_waits;
   int          waits;
   int          n_checks;
   int          n_errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_err(input logic [2:0] size, input logic [1:0] off);
      if (size > 3'd2) return 1'b1;
      if (size == 3'd1 && off[0]) return 1'b1;
      if (size == 3'd2 && off != 2'd0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] merge_ref(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [2:0] size, input logic [1:0] off);
      logic [31:0] r;
      int nb;
      r  = old_w;
      nb = 1 << size;
      for (int i = 0; i < 4; i++)
         if (i >= int'(off) && i < int'(off) + nb) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic write,
                                input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      xfer_t t;
      t.sel = sel; t.trans = trans; t.write = write; t.size = size; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   task automatic drive_ap();
      bus.HSEL   = ap.sel;
      bus.HTRANS = ap.trans;
      bus.HWRITE = ap.write;
      bus.HSIZE  = ap.size;
      bus.HADDR  = ap.addr;
   endtask

   task automatic run_cycles();
      logic       exp_rdy, exp_wren;
      logic [9:0] idx;
      bit         wr_done;
      int         guard;
      guard = 0;
      while ((q.size() > 0 || dp_vld || (ap.sel && ap.trans[1])) && guard < 5000) begin
         guard++;
         @(negedge clk);
         idx      = dp.addr[11:2];
         exp_rdy  = !dp_vld || (waits >= dp_exp_waits);
         exp_wren = dp_vld && dp.write && !dp_err && exp_rdy;
         check("hreadyout", 32'(bus.HREADYOUT), 32'(exp_rdy));
         check("hresp", 32'(bus.HRESP), 32'(dp_vld && dp_err));
         check("hrdata", bus.HRDATA,
               (dp_vld && !dp.write && !dp_err && exp_rdy) ? ref_mem[idx] : 32'h0);
         check("sram_wren", 32'(sram_wren), 32'(exp_wren));
         if (exp_wren) begin
            check("wr_addr", 32'(sram_addr), 32'(idx));
            check("wr_data", sram_data, merge_ref(ref_mem[idx], dp.wdata, dp.size, dp.addr[1:0]));
         end
         if (bus.HREADYOUT) begin
            wr_done = dp_vld && dp.write && !dp_err;
            if (wr_done) ref_mem[idx] = merge_ref(ref_mem[idx], dp.wdata, dp.size, dp.addr[1:0]);
            if (ap.sel && ap.trans[1]) begin
               dp     = ap;
               dp_vld = 1'b1;
               dp_err = is_err(ap.size, ap.addr[1:0]);
               waits  = 0;
               if (dp_err)                dp_exp_waits = 1;
               else if (ap.write)         dp_exp_waits = (ap.size == 3'd2) ? 0 : 1;
               else                       dp_exp_waits = wr_done ? 1 : 0;
            end else begin
               dp_vld = 1'b0;
            end
            ap = (q.size() > 0) ? q.pop_front() : mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
         drive_ap();
         bus.HWDATA = (dp_vld && dp.write) ? dp.wdata : $urandom();
      end
      check("run_done", 32'(guard < 5000), 32'd1);
   endtask

   initial begin
      xfer_t t;
      int    r, off;
      n_checks = 0;
      n_errors = 0;
      dp_vld   = 1'b0;
      dp_err   = 1'b0;
      waits    = 0;
      dp_exp_waits = 0;
      ap       = mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
      dp       = ap;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      load = 1'b1;
      rst  = 1'b1;
      drive_ap();
      bus.HWDATA = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check("rst_hresp", 32'(bus.HRESP), 32'd0);
      check("rst_hrdata", bus.HRDATA, 32'h0);
      check("rst_wren", 32'(sram_wren), 32'd0);
      @(posedge clk);
      #1;
      load = 1'b0;
      rst  = 1'b0;

      // Directed sequence
      q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h010, 32'hDEAD_BEEF));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'h0));
      q.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h000, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'h0));
      q.push_back(mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h014, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h012, 32'h00AB_0000));
      q.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h000, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h010, 32'h0000_CAFE));
      q.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h000, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h011, 32'h1234_5678));
      q.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h000, 32'h0));
      q.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'h0));
      q.push_back(mk(0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h000, 32'h0));
      run_cycles();
      check("tp_mem_010", mem[4], 32'hDEAB_CAFE);
      check("tp_mem_014", mem[5], 32'h1111_1111);

      // Random traffic over a small window so reads hit earlier writes
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         t.sel   = ($urandom_range(0, 9) != 0);
         t.trans = (r < 15) ? HTRANS_IDLE : (r < 22) ? HTRANS_BUSY :
                   (r < 70) ? HTRANS_NONSEQ : HTRANS_SEQ;
         t.write = 1'($urandom_range(0, 1));
         t.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         off     = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0) begin
            if (t.size == 3'd1) off = off & 2;
            else if (t.size == 3'd2) off = 0;
         end
         t.addr  = (32'($urandom_range(0, 1023)) << 12) | (32'($urandom_range(0, 15)) << 2) | 32'(off);
         t.wdata = $urandom();
         q.push_back(t);
      end
      q.push_back(mk(0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h000, 32'h0));
      run_cycles();
      for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);

      // Reset while a byte write sits in its read half
      @(posedge clk);
      #1;
      bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
      bus.HSIZE = HSIZE_BYTE; bus.HADDR = 32'h020;
      @(posedge clk);
      #1;
      bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWDATA = 32'h0000_00FF;
      @(negedge clk);
      check("rmw_wait", 32'(bus.HREADYOUT), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rmw_rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check("rmw_rst_hresp", 32'(bus.HRESP), 32'd0);
      check("rmw_rst_hrdata", bus.HRDATA, 32'h0);
      check("rmw_rst_wren", 32'(sram_wren), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("post_rst_wren", 32'(sram_wren), 32'd0);
      end
      check("rmw_rst_mem", mem[8], ref_mem[8]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-lite slave front end for the 1024x32 single-port synchronous SRAM (registered read address, 1-cycle read latency, word-only write enable). It decodes AHB-lite transfers and sequences the SRAM port. Sub-word writes are done as read-modify-write, and SRAM port conflicts are resolved with wait states. Sits between the AHB-lite interconnect/decoder and sram_1024x32.

Parameters:
MEM_AW, 10, SRAM word-address width; HADDR[MEM_AW+1:2] is the word index.
DW, 32, data width; fixed at 32, byte lanes little-endian.

Ports:
clk  in  1  single clock for the bus and SRAM.
rst  in  1  synchronous, active-high reset.
HSEL  in  1  slave select from decoder.
HADDR  in  32  address-phase address.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HWRITE  in  1  1 = write.
HSIZE  in  3  0 = byte, 1 = half, 2 = word.
HWDATA  in  32  write data, valid in data phase.
HREADY  in  1  bus-level ready (previous transfer completing).
HREADYOUT  out  1  this slave's ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.
HRDATA  out  32  read data.
sram_addr  out  MEM_AW  to SRAM addr.
sram_data  out  32  to SRAM data.
sram_wren  out  1  to SRAM wren.
sram_q  in  32  from SRAM q.

Behaviour:
- Transfer acceptance: accept = HSEL & HREADY & HTRANS[1]. On accept, latch word address, byte offset HADDR[1:0], HSIZE and HWRITE.
- IDLE and BUSY transfers get an OKAY, zero-wait response.
- ERROR conditions: HSIZE>2, half-word with HADDR[0]=1, or word with HADDR[1:0]!=0.
- States: IDLE, RD, RDW, WR, RMW_RD, RMW_WR, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0, sram_wren=0. sram_addr=HADDR word index (lookahead read).
- Next state after an accepted transfer (same rule applies from IDLE, RD, RDW-final, WR, RMW_WR and ERR2):
  - error -> ERR1
  - read -> RD, or RDW if the current cycle drives sram_wren=1
  - word write -> WR
  - sub-word write -> RMW_RD
  - no accept -> IDLE
- RD: HRDATA=sram_q, HREADYOUT=1. sram_addr=HADDR lookahead, so back-to-back reads run at zero wait.
- RDW: read following a write. Cycle 1: sram_addr=latched address, HREADYOUT=0. Cycle 2: behaves as RD. Internal flag selects between the two cycles.
- WR: sram_addr=latched address, sram_data=HWDATA, sram_wren=1, HREADYOUT=1. Zero wait.
- RMW_RD: sram_addr=latched address, sram_wren=0, HREADYOUT=0.
- RMW_WR: sram_data = sram_q with lanes selected by size/offset replaced from HWDATA; sram_wren=1, HREADYOUT=1. Exactly one wait state.
- ERR1: HRESP=1, HREADYOUT=0. ERR2: HRESP=1, HREADYOUT=1. SRAM is never written on an error transfer.
- HRDATA is 0 outside the final read cycle. HRESP=0 in every state except ERR1/ERR2.
- Read-after-write to the same address returns the new data. The write commits at the edge before the RDW address is registered.
- HWDATA is sampled only in the cycle where sram_wren=1. Per AHB-lite it is stable across wait states.
- Reset (any cycle, including mid-RMW or mid-error): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, sram_wren=0, all latches cleared. A pending write is dropped.
- HSEL=0 with HREADY=1 while in IDLE: no SRAM write, outputs stay idle.

Decomposition:
- Package ahb_lite_pkg: HTRANS encodings, HSIZE encodings, HRESP_OKAY/HRESP_ERROR, state enum.
- Sub-module ahb_sram_byte_merge (combinational). Inputs: old word, new word, size, offset. Outputs: merged word and 4-bit lane mask.
- The FSM stays in the top module.

Test Plan:
- Word write 0xDEADBEEF @0x010, then word read @0x010 -> write HREADYOUT=1 zero wait; read RDW, one wait state, HRDATA=0xDEADBEEF.
- Back-to-back reads @0x010, 0x014 (preloaded 0x11111111) -> zero wait each; HRDATA 0xDEADBEEF then 0x11111111.
- Byte write 0xAB @0x012 over 0xDEADBEEF -> one wait state, sram_wren once with 0xDEABBEEF; readback 0xDEABBEEF.
- Half write HWDATA=0x0000CAFE @0x010 -> memory 0xDEABCAFE.
- Word write @0x011 -> HRESP=1 for two cycles (HREADYOUT 0 then 1), sram_wren never asserted, memory unchanged.
- Assert rst during RMW_RD of a byte write -> next cycle HREADYOUT=1, HRESP=0, sram_wren=0; target word unchanged.
